// File: rtl/gol_pkg.sv
// Shared types and constants for the Game of Life array and its peripheral blocks.
package gol_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } gol_readout_state_t;

    localparam int GOL_FRAME_CNT_W = 16;

    // Row-index width, kept at least one bit so a single-row array still has a port.
    function automatic int golIdxW(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gol_row_popcount.sv
// Purely combinational ones-count of one array row (used when GOL_READOUT_POPCOUNT_EN is defined).
module gol_row_popcount #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0]            i_row,
    output logic [$clog2(WIDTH+1)-1:0]  o_count
);

    localparam int CW = $clog2(WIDTH + 1);

    always_comb begin
        o_count = '0;
        for (int c = 0; c < WIDTH; c++) begin
            o_count = o_count + CW'(i_row[c]);
        end
    end

endmodule

// File: rtl/gol_readout.sv
// Snapshot-and-stream readout for the Game of Life array: one row per valid/ready beat.
// Optional feature macro GOL_READOUT_POPCOUNT_EN adds a live-cell count of each completed frame.
module gol_readout
    import gol_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [WIDTH*HEIGHT-1:0]           cells,
    input  logic                              snap,
    output logic                              busy,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIDTH-1:0]                  out_row,
    output logic [golIdxW(HEIGHT)-1:0]        out_row_idx,
    output logic                              out_last,
    output logic                              done,
`ifdef GOL_READOUT_POPCOUNT_EN
    output logic [$clog2(WIDTH*HEIGHT+1)-1:0] pop_count,
`endif
    output logic [GOL_FRAME_CNT_W-1:0]        frame_cnt
);

    localparam int IDXW = golIdxW(HEIGHT);
    localparam logic [IDXW-1:0] LAST_ROW = IDXW'(HEIGHT - 1);

    gol_readout_state_t r_state, w_nextState;
    logic [WIDTH*HEIGHT-1:0] r_shadow, w_nextShadow;
    logic [IDXW-1:0] r_row, w_nextRow;
    logic r_busy, r_outValid, r_outLast, r_done;
    logic [WIDTH-1:0] r_outRow;
    logic [GOL_FRAME_CNT_W-1:0] r_frameCnt;
    logic w_accept;

    assign w_accept = r_outValid & out_ready;

    always_comb begin
        w_nextState  = r_state;
        w_nextShadow = r_shadow;
        w_nextRow    = r_row;
        case (r_state)
            IDLE: begin
                if (snap) begin
                    w_nextState  = SEND;
                    w_nextShadow = cells;
                    w_nextRow    = '0;
                end
            end
            SEND: begin
                if (w_accept) begin
                    if (r_row == LAST_ROW) begin
                        w_nextState = DONE;
                    end else begin
                        w_nextRow = r_row + IDXW'(1);
                    end
                end
            end
            DONE: begin
                w_nextState = IDLE;
                w_nextRow   = '0;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Every output is computed from next-state values so nothing combinational reaches a port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shadow   <= '0;
            r_row      <= '0;
            r_busy     <= 1'b0;
            r_outValid <= 1'b0;
            r_outRow   <= '0;
            r_outLast  <= 1'b0;
            r_done     <= 1'b0;
            r_frameCnt <= '0;
        end else begin
            r_state    <= w_nextState;
            r_shadow   <= w_nextShadow;
            r_row      <= w_nextRow;
            r_busy     <= (w_nextState != IDLE);
            r_outValid <= (w_nextState == SEND);
            r_outRow   <= (w_nextState == SEND) ? w_nextShadow[int'(w_nextRow)*WIDTH +: WIDTH] : '0;
            r_outLast  <= (w_nextState == SEND) && (w_nextRow == LAST_ROW);
            r_done     <= (w_nextState == DONE);
            if (w_nextState == DONE) begin
                r_frameCnt <= r_frameCnt + GOL_FRAME_CNT_W'(1);
            end
        end
    end

    assign busy        = r_busy;
    assign out_valid   = r_outValid;
    assign out_row     = r_outRow;
    assign out_row_idx = r_row;
    assign out_last    = r_outLast;
    assign done        = r_done;
    assign frame_cnt   = r_frameCnt;

`ifdef GOL_READOUT_POPCOUNT_EN
    localparam int PCW = $clog2(WIDTH*HEIGHT + 1);
    localparam int RCW = $clog2(WIDTH + 1);

    logic [RCW-1:0] w_rowPop;
    logic [PCW-1:0] r_popAcc, r_popCount, w_popSum;

    gol_row_popcount #(.WIDTH(WIDTH)) u_rowPop (
        .i_row   (r_outRow),
        .o_count (w_rowPop)
    );

    assign w_popSum = r_popAcc + PCW'(w_rowPop);

    // The published count only moves when the last beat lands, so an aborted frame leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_popAcc   <= '0;
            r_popCount <= '0;
        end else begin
            if ((r_state == IDLE) && snap) begin
                r_popAcc <= '0;
            end else if (w_accept) begin
                r_popAcc <= w_popSum;
            end
            if (w_accept && r_outLast) begin
                r_popCount <= w_popSum;
            end
        end
    end

    assign pop_count = r_popCount;
`endif

endmodule

// File: tb/tb_gol_readout.sv
// Scoreboard bench for gol_readout: a frame model feeds expectation queues, a monitor checks beats.
`timescale 1ns/1ps
module tb_gol_readout;

    localparam int W    = 10;
    localparam int H    = 10;
    localparam int N    = W * H;
    localparam int IDXW = 4;
    localparam int PCW  = $clog2(N + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] cells = '0;
    logic snap = 1'b0;
    logic out_ready = 1'b0;
    logic busy, out_valid, out_last, done;
    logic [W-1:0] out_row;
    logic [IDXW-1:0] out_row_idx;
    logic [15:0] frame_cnt;
`ifdef GOL_READOUT_POPCOUNT_EN
    logic [PCW-1:0] pop_count;
`endif

    typedef struct {
        logic [W-1:0] row;
        int           idx;
        logic         last;
    } beat_t;

    typedef struct {
        logic [15:0] cnt;
        int          pop;
    } frame_t;

    beat_t  expQ[$];
    frame_t frameQ[$];

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] modelFrames = '0;
    int readyMode = 0;
    int readyPhase = 0;
    int acceptedInFrame = 0;
    bit prevLast = 1'b0;
    bit lastSeen = 1'b0;

    gol_readout #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk         (clk),
        .rst         (rst),
        .cells       (cells),
        .snap        (snap),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_row_idx (out_row_idx),
        .out_last    (out_last),
        .done        (done),
`ifdef GOL_READOUT_POPCOUNT_EN
        .pop_count   (pop_count),
`endif
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_out_row"}, out_row, 0);
        checkOutput({tag, "_out_row_idx"}, out_row_idx, 0);
        checkOutput({tag, "_out_last"}, out_last, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    // Frame model: slice the snapshot into rows, count live cells, bump the frame counter.
    task automatic pushFrame(input logic [N-1:0] img);
        beat_t  b;
        frame_t f;
        int     pop = 0;
        for (int r = 0; r < H; r++) begin
            b.row  = W'(img >> (r * W));
            b.idx  = r;
            b.last = (r == H - 1);
            expQ.push_back(b);
        end
        for (int i = 0; i < N; i++) begin
            if (img[i]) pop++;
        end
        modelFrames = modelFrames + 16'd1;
        f.cnt = modelFrames;
        f.pop = pop;
        frameQ.push_back(f);
    endtask

    task automatic applyStimulus(input logic [N-1:0] img);
        cells = img;
        snap = 1'b1;
        acceptedInFrame = 0;
        pushFrame(img);
        @(posedge clk);
        #1 snap = 1'b0;
        @(negedge clk);
        checkOutput("first_valid", out_valid, 1);
        checkOutput("first_busy", busy, 1);
    endtask

    task automatic waitFrameDone();
        int n = 0;
        while ((frameQ.size() != 0 || expQ.size() != 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (n >= 400) begin
            checkOutput("frame_timeout", frameQ.size(), 0);
            frameQ.delete();
            expQ.delete();
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] randomImage();
        return N'({$urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(3) != 0);
                default: begin
                    out_ready = ((readyPhase % 4) == 0) || ((readyPhase % 4) == 3);
                    readyPhase++;
                end
            endcase
        end
    end

    // Monitor: compares whatever the DUT presents against the head of the expectation queues.
    initial begin
        beat_t  b;
        frame_t f;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevLast = 1'b0;
                acceptedInFrame = 0;
                continue;
            end
            if (done || prevLast) checkOutput("done_pulse", done, prevLast);
            if (done) begin
                checkOutput("busy_in_done", busy, 1);
                if (frameQ.size() == 0) begin
                    checkOutput("unexpected_done", done, 0);
                end else begin
                    f = frameQ.pop_front();
                    checkOutput("frame_cnt", frame_cnt, f.cnt);
`ifdef GOL_READOUT_POPCOUNT_EN
                    checkOutput("pop_count", pop_count, f.pop);
`endif
                end
            end
            prevLast = 1'b0;
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_valid", out_valid, 0);
                end else begin
                    b = expQ[0];
                    checkOutput("out_row", out_row, b.row);
                    checkOutput("out_row_idx", out_row_idx, b.idx);
                    checkOutput("out_last", out_last, b.last);
                    checkOutput("busy_in_send", busy, 1);
                    if (out_ready) begin
                        void'(expQ.pop_front());
                        acceptedInFrame++;
                        if (b.last) begin
                            prevLast = 1'b1;
                            lastSeen = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got hang, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [N-1:0] img;
        int n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset_hold");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkResetOutputs("reset_release");
        @(posedge clk);
        #1;

        $display("[TB] identity frame");
        readyMode = 0;
        img = '0;
        for (int i = 0; i < N; i++) img[i] = ((i % 11) == 0);
        applyStimulus(img);
        waitFrameDone();

        $display("[TB] backpressure 1,0,0,1");
        readyMode = 2;
        readyPhase = 0;
        applyStimulus(randomImage());
        waitFrameDone();

        $display("[TB] glider snapshot while cells go all-ones");
        readyMode = 1;
        img = '0;
        img[0*W+1] = 1'b1;
        img[1*W+2] = 1'b1;
        img[2*W+0] = 1'b1;
        img[2*W+1] = 1'b1;
        img[2*W+2] = 1'b1;
        applyStimulus(img);
        cells = '1;
        waitFrameDone();

        $display("[TB] snap during SEND and DONE");
        readyMode = 0;
        lastSeen = 1'b0;
        applyStimulus(randomImage());
        @(posedge clk);
        #1 snap = 1'b1;
        @(posedge clk);
        #1 snap = 1'b0;
        n = 0;
        while (!lastSeen && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (n >= 100) checkOutput("last_timeout", lastSeen, 1);
        #1 snap = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(randomImage());
        waitFrameDone();

        $display("[TB] reset mid-frame");
        readyMode = 0;
        applyStimulus(randomImage());
        n = 0;
        while (acceptedInFrame < 5 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (n >= 100) checkOutput("row4_timeout", acceptedInFrame, 5);
        #1 rst = 1'b1;
        expQ.delete();
        frameQ.delete();
        modelFrames = '0;
        @(negedge clk);
        checkResetOutputs("abort");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        checkOutput("frame_cnt_after_abort", frame_cnt, modelFrames);
        @(posedge clk);
        #1;

        $display("[TB] randomized frames");
        readyMode = 1;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(randomImage());
            waitFrameDone();
        end

        $display("[TB] frame counter wrap");
        readyMode = 0;
        force dut.r_frameCnt = 16'hFFFF;
        @(posedge clk);
        #1 release dut.r_frameCnt;
        modelFrames = 16'hFFFF;
        @(negedge clk);
        checkOutput("frame_cnt_preload", frame_cnt, modelFrames);
        @(posedge clk);
        #1;
        applyStimulus(randomImage());
        waitFrameDone();
        applyStimulus(randomImage());
        waitFrameDone();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gol_readout.md
# gol_readout

Downstream readout stage for the Game of Life array. On request it snapshots the full `cells` vector and streams it out one row per valid/ready handshake, top row first. It gives host logic, display drivers or scoreboards a consistent frame even while the array keeps stepping, and counts completed frames.

## Interface
Parameters:
- `WIDTH`, 10, columns per row; must match the array.
- `HEIGHT`, 10, number of rows; must match the array.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cells`  in  WIDTH*HEIGHT  live array state. Cell (r,c) is bit `r*WIDTH+c`; row 0 is the top row, column 0 is the left column.
- `snap`  in  1  single-cycle frame request; sampled only in IDLE.
- `busy`  out  1  high in SEND and DONE.
- `out_valid`  out  1  row beat valid.
- `out_ready`  in  1  consumer accepts the beat.
- `out_row`  out  WIDTH  row data; bit c = column c.
- `out_row_idx`  out  $clog2(HEIGHT) (min 1)  index of the current row.
- `out_last`  out  1  high with the beat for row HEIGHT-1.
- `done`  out  1  one-cycle pulse after the last beat is accepted.
- `frame_cnt`  out  16  number of completed frames; wraps 0xFFFF→0.

## Operation
- FSM states: IDLE, SEND, DONE.
- **IDLE**
  - When `snap`=1: latch `cells` into the shadow register, clear the row counter, go to SEND.
  - When `snap`=0: stay in IDLE.
- **SEND**
  - `out_valid`=1.
  - `out_row` = shadow[row*WIDTH +: WIDTH].
  - `out_row_idx` = row.
  - `out_last` = (row==HEIGHT-1).
  - On handshake (`out_valid & out_ready`):
    - If `out_last`: go to DONE.
    - Otherwise: row++.
  - Without a handshake, all out_* signals hold stable.
- **DONE**
  - `done`=1 for exactly one cycle.
  - `frame_cnt`++ (wrapping).
  - Return to IDLE.
- `snap` in SEND or DONE is ignored and is not queued.
- The shadow register is written only on an accepted `snap`. Changes on `cells` during a frame never affect the streamed data.
- HEIGHT=1: the single beat carries `out_last`=1.
- The row counter never exceeds HEIGHT-1. It holds at that value until the FSM leaves SEND.

## Timing
- Reset values: state IDLE, `busy`=0, `out_valid`=0, `out_row`=0, `out_row_idx`=0, `out_last`=0, `done`=0, `frame_cnt`=0, shadow=0.
- Reset asserted mid-frame aborts immediately, with no `done` and no `frame_cnt` increment.
- `snap` high in cycle N → `busy`=1 and `out_valid`=1 with row 0 in cycle N+1.
- Each row needs one accepted beat. With `out_ready` held at 1, the frame takes HEIGHT cycles of `out_valid`.
- Last beat accepted in cycle M → `done`=1 and `frame_cnt` updated in cycle M+1 → IDLE in cycle M+2. The earliest next `snap` is sampled in cycle M+2.
- All outputs are registered; there is no combinational path from `out_ready` to any output.

## Configuration
- Macro: `GOL_READOUT_POPCOUNT_EN`.
- **Defined:**
  - Adds output `pop_count` (out, $clog2(WIDTH*HEIGHT+1)): the number of live cells in the last completed frame.
  - An internal accumulator clears on snap acceptance and adds the popcount of each accepted row.
  - `pop_count` updates in the DONE cycle, together with `done`.
  - Reset value 0; an aborted frame leaves it unchanged.
- **Undefined:** the port and the accumulator are absent. All other behaviour is identical.

## Structure
- Shared package `gol_pkg` holds:
  - `gol_readout_state_t` enum {IDLE, SEND, DONE}.
  - `GOL_FRAME_CNT_W` = 16.
- Sub-module `gol_row_popcount` (parameter WIDTH): purely combinational ones-count of one row. Instantiated only under `GOL_READOUT_POPCOUNT_EN`.

## Test plan
- Reset, then `snap` with `cells` = identity pattern (bit i = (i%11==0)) on 10x10, `out_ready`=1:
  - Rows arrive as 0x001, 0x002, …, 0x200 in order.
  - `out_last` is set on row 9; `done` one cycle later; `frame_cnt`=1.
- Backpressure:
  - `out_ready` toggles 1,0,0,1 repeatedly.
  - `out_row` and `out_row_idx` stay stable during stalls; all 10 rows are delivered exactly once.
- Change `cells` to all-ones during a frame captured from a glider pattern:
  - Streamed rows equal the glider snapshot.
  - With the macro defined, `pop_count`=5.
- `snap` pulsed in SEND and in DONE:
  - Both are ignored; `frame_cnt` increments by exactly 1.
  - A `snap` in the following IDLE cycle starts a new frame.
- Assert `rst` after row 4 is accepted:
  - All outputs read 0 next cycle; `done` never pulses; `frame_cnt`=0.
- Preload 0xFFFF completed frames, then complete one more frame: `frame_cnt` wraps to 0.
